fmap_stream_tx: RTL

FMAP_STREAM_TX -- requirements
Module: fmap_stream_tx

---
 rtl/fmap_stream_tx_pkg.sv | 26 ++
 rtl/fmap_addr_gen.sv | 79 +++++++
 rtl/fmap_stream_tx.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/fmap_stream_tx_pkg.sv
// fmap_stream_tx_pkg
//   Definitions shared by the feature-map streamer and the conv core:
//   FSM state encoding, memory read latency, default frame geometry and a
//   counter-width helper.
package fmap_stream_tx_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_GAP   = 2'd2,
        S_DRAIN = 2'd3
    } fsm_state_e;

    // Cycles from an issued read to its pixel appearing on the output.
    localparam int RD_LAT = 2;

    localparam int DEF_I_F_BW = 8;
    localparam int DEF_IW     = 28;
    localparam int DEF_IH     = 28;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int cnt_bw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fmap_addr_gen.sv
// fmap_addr_gen
//   Raster-order column/row/address counters for one frame.
//   Ports:
//     clk, reset_n   clock, asynchronous active-low reset
//     clear_i        return all counters to 0 (frame start)
//     adv_i          one read was issued this cycle; advance to next pixel
//     addr_o         current read address (row*IW + col, kept incrementally)
//     last_col_o     current column is IW-1
//     last_row_o     current row is IH-1
module fmap_addr_gen
    import fmap_stream_tx_pkg::*;
#(
    parameter int IW      = DEF_IW,
    parameter int IH      = DEF_IH,
    parameter int ADDR_BW = 10
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clear_i,
    input  logic               adv_i,
    output logic [ADDR_BW-1:0] addr_o,
    output logic               last_col_o,
    output logic               last_row_o
);

    localparam int CW = cnt_bw(IW);
    localparam int RW = cnt_bw(IH);
    localparam logic [CW-1:0] COL_LAST = CW'(IW - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IH - 1);

    logic [CW-1:0]      col_q,  col_d;
    logic [RW-1:0]      row_q,  row_d;
    logic [ADDR_BW-1:0] addr_q, addr_d;

    assign last_col_o = (col_q == COL_LAST);
    assign last_row_o = (row_q == ROW_LAST);
    assign addr_o     = addr_q;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        col_d  = col_q;
        row_d  = row_q;
        addr_d = addr_q;
        if (clear_i) begin
            col_d  = '0;
            row_d  = '0;
            addr_d = '0;
        end else if (adv_i) begin
            if (last_col_o) begin
                col_d = '0;
                if (last_row_o) begin
                    // Final pixel: wrap everything so the next frame starts at 0.
                    row_d  = '0;
                    addr_d = '0;
                end else begin
                    row_d  = row_q + RW'(1);
                    addr_d = addr_q + ADDR_BW'(1);
                end
            end else begin
                col_d  = col_q + CW'(1);
                addr_d = addr_q + ADDR_BW'(1);
            end
        end
    end

    // NOTE: state updates use non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col_q  <= '0;
            row_q  <= '0;
            addr_q <= '0;
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            addr_q <= addr_d;
        end
    end

endmodule

// File: rtl/fmap_stream_tx.sv
// fmap_stream_tx
//   Streams one IW x IH frame from a frame memory to the conv core in raster
//   order, with optional idle cycles between rows and a hold input that
//   pauses new reads without losing reads already in flight.
//   Ports:
//     clk, reset_n   clock, asynchronous active-low reset
//     i_start        single-cycle frame start request (ignored while busy/done)
//     i_hold         suspends new reads while high
//     o_rd_en        frame-memory read strobe
//     o_rd_addr      frame-memory read address
//     i_rd_data      frame-memory data, valid the cycle after o_rd_en
//     o_ot_valid     pixel valid (RD_LAT cycles after the read)
//     o_ot_pixel     pixel, holds last value when o_ot_valid is low
//     o_busy         frame in progress
//     o_done         single-cycle frame-complete pulse
module fmap_stream_tx
    import fmap_stream_tx_pkg::*;
#(
    parameter int I_F_BW  = DEF_I_F_BW,
    parameter int IW      = DEF_IW,
    parameter int IH      = DEF_IH,
    parameter int ADDR_BW = 10,
    parameter int GAP     = 0
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               i_start,
    input  logic               i_hold,
    output logic               o_rd_en,
    output logic [ADDR_BW-1:0] o_rd_addr,
    input  logic [I_F_BW-1:0]  i_rd_data,
    output logic               o_ot_valid,
    output logic [I_F_BW-1:0]  o_ot_pixel,
    output logic               o_busy,
    output logic               o_done
);

    localparam int GW = cnt_bw(GAP);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

    fsm_state_e        state_q;
    logic [GW-1:0]     gap_cnt_q;
    logic              busy_q;
    logic              done_q;
    logic              rd_inflight_q;   // read issued last cycle, data on i_rd_data now
    logic              vld_q;
    logic [I_F_BW-1:0] pix_q;

    logic rd_en;
    logic start_ok;
    logic last_col;
    logic last_row;

    // Hold must gate the strobe in the same cycle, so the strobe is decoded
    // from the registered state rather than registered itself.
    assign rd_en    = (state_q == S_READ) && !i_hold;
    assign start_ok = (state_q == S_IDLE) && i_start && !done_q;

    fmap_addr_gen #(
        .IW      (IW),
        .IH      (IH),
        .ADDR_BW (ADDR_BW)
    ) u_addr_gen (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear_i    (start_ok),
        .adv_i      (rd_en),
        .addr_o     (o_rd_addr),
        .last_col_o (last_col),
        .last_row_o (last_row)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            gap_cnt_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start_ok) begin
                        state_q <= S_READ;
                        busy_q  <= 1'b1;
                    end
                end
                S_READ: begin
                    if (rd_en && last_col) begin
                        if (last_row) begin
                            state_q <= S_DRAIN;
                        end else if (GAP > 0) begin
                            state_q   <= S_GAP;
                            gap_cnt_q <= '0;
                        end
                    end
                end
                S_GAP: begin
                    // Counts every cycle; hold only affects reads.
                    if (gap_cnt_q == GAP_LAST) begin
                        state_q <= S_READ;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + GW'(1);
                    end
                end
                S_DRAIN: begin
                    // The last pixel is on the output this cycle; done follows it.
                    if (!rd_inflight_q) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Output pipeline: capture memory data one cycle after the read, present
    // it registered on the following cycle (RD_LAT total).
    // NOTE: only control/data flops here, no memory array, so all of them take the async reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_inflight_q <= 1'b0;
            vld_q         <= 1'b0;
            pix_q         <= '0;
        end else begin
            rd_inflight_q <= rd_en;
            vld_q         <= rd_inflight_q;
            if (rd_inflight_q) begin
                pix_q <= i_rd_data;
            end
        end
    end

    assign o_rd_en    = rd_en;
    assign o_ot_valid = vld_q;
    assign o_ot_pixel = pix_q;
    assign o_busy     = busy_q;
    assign o_done     = done_q;

endmodule
